rd_sel_arbiter: RTL and testbench

Round-robin read arbiter for the four sub-queues of the special queue. It watches per-queue occupancy flags and issues a registered one-hot read select `rd_sel[3:0]` with a valid/ready handshake to the read path. That select feeds the one-hot-to-index decoder directly downstream. Fairness is rotating priority, and a queue with more than one entry can be granted on consecutive cycles with no bubble.

---
 rtl/special_queue_pkg.sv | 26 ++
 rtl/rd_sel_arbiter_rr_pick.sv | 28 ++
 rtl/rd_sel_arbiter.sv | 124 ++++++++++++
 tb/tb_rd_sel_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/special_queue_pkg.sv
// Shared types and helpers for the special queue read path (arbiter and one-hot decoder).
package special_queue_pkg;

  localparam int unsigned NQ      = 4;
  localparam int unsigned OH_W    = NQ;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned BCNT_W  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic logic [OH_W-1:0] onehot4(input logic [IDX_W-1:0] idx);
    onehot4 = OH_W'(1) << idx;
  endfunction

  // Index of the set bit; only meaningful for a one-hot input.
  function automatic logic [IDX_W-1:0] oh_to_idx(input logic [OH_W-1:0] oh);
    oh_to_idx = '0;
    for (int i = 0; i < int'(OH_W); i++) begin
      if (oh[i]) oh_to_idx = oh_to_idx | IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/rd_sel_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set bit of req searching from ptr upward, mod 4.
module rr_pick
  import special_queue_pkg::*;
(
  input  logic [OH_W-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [OH_W-1:0]  gnt,
  output logic             any
);

  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    gnt   = '0;
    any   = |req;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < int'(OH_W); k++) begin
      idx = ptr + IDX_W'(k);
      if (!found && req[idx]) begin
        gnt   = onehot4(idx);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rd_sel_arbiter.sv
// Round-robin read arbiter for the four special-queue sub-queues; registered one-hot rd_sel.
// Optional per-queue burst grants are compiled in with `define RR_BURST_EN.
module rd_sel_arbiter
  import special_queue_pkg::*;
#(
  parameter int unsigned NQ        = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OH_W-1:0] q_nonempty,
  input  logic [OH_W-1:0] q_last,
  input  logic            rd_ready,
  output logic            rd_valid,
  output logic [OH_W-1:0] rd_sel
);

  // The downstream decoder is fixed at four one-hot inputs.
  if (NQ != OH_W || MAX_BURST == 0 || MAX_BURST > 15) begin : g_bad_cfg
    $error("rd_sel_arbiter: unsupported NQ or MAX_BURST");
  end

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [OH_W-1:0]  sel_d;
  logic             valid_d;

  logic [IDX_W-1:0] g;
  logic             fire;
  logic [OH_W-1:0]  req_eff;
  logic [OH_W-1:0]  pick_req;
  logic [IDX_W-1:0] pick_ptr;
  logic [OH_W-1:0]  pick_gnt;
  logic             pick_any;
  logic             burst_keep;

  assign g       = oh_to_idx(rd_sel);
  assign fire    = rd_valid & rd_ready;
  // A queue drained by the current pop no longer competes.
  assign req_eff = q_nonempty & ~(rd_sel & q_last);

  assign pick_req = (state_q == GRANT) ? req_eff : q_nonempty;
  assign pick_ptr = (state_q == GRANT) ? (g + IDX_W'(1)) : ptr_q;

  rr_pick u_pick (
    .req (pick_req),
    .ptr (pick_ptr),
    .gnt (pick_gnt),
    .any (pick_any)
  );

`ifdef RR_BURST_EN
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;

  assign burst_keep = req_eff[g] && (bcnt_q < BCNT_W'(MAX_BURST - 1));

  always_ff @(posedge clk) begin
    if (rst) bcnt_q <= '0;
    else     bcnt_q <= bcnt_d;
  end
`else
  assign burst_keep = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      rd_sel   <= '0;
      rd_valid <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rd_sel   <= sel_d;
      rd_valid <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = rd_sel;
    valid_d = rd_valid;
`ifdef RR_BURST_EN
    bcnt_d  = bcnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          sel_d   = pick_gnt;
          valid_d = 1'b1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (fire) begin
          if (burst_keep) begin
`ifdef RR_BURST_EN
            bcnt_d = bcnt_q + BCNT_W'(1);
`endif
          end else begin
            ptr_d = g + IDX_W'(1);
`ifdef RR_BURST_EN
            bcnt_d = '0;
`endif
            if (pick_any) begin
              sel_d = pick_gnt;
            end else begin
              sel_d   = '0;
              valid_d = 1'b0;
              state_d = IDLE;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rd_sel_arbiter.sv
// Scoreboard bench for rd_sel_arbiter: occupancy-count model drives inputs, monitor checks each cycle.
module tb_rd_sel_arbiter;

`ifdef RR_BURST_EN
  localparam int unsigned MB    = 3;
  localparam bit          BURST = 1'b1;
`else
  localparam int unsigned MB    = 4;
  localparam bit          BURST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] q_nonempty;
  logic [3:0] q_last;
  logic       rd_ready;
  logic       rd_valid;
  logic [3:0] rd_sel;

  always #5 clk = ~clk;

  rd_sel_arbiter #(.NQ(4), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .rst        (rst),
    .q_nonempty (q_nonempty),
    .q_last     (q_last),
    .rd_ready   (rd_ready),
    .rd_valid   (rd_valid),
    .rd_sel     (rd_sel)
  );

  // Sub-queue occupancy and the reference arbiter's view of the world.
  int         cnt [4];
  bit         m_valid;
  int         m_g;
  int         m_ptr;
  int         m_bcnt;
  logic [4:0] exp_q [$];
  int         errors = 0;
  int         checks = 0;

  function automatic int first_from(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  // Drive one cycle of inputs and push the outputs expected after the next rising edge.
  task automatic step(input logic r, input logic rdy);
    logic [3:0] ne, la, req, oh;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      ne[i] = (cnt[i] > 0);
      la[i] = (cnt[i] == 1);
    end
    rst        = r;
    rd_ready   = rdy;
    q_nonempty = ne;
    q_last     = la;
    if (r) begin
      m_valid = 1'b0;
      m_ptr   = 0;
      m_bcnt  = 0;
    end else if (!m_valid) begin
      if (ne != 4'b0000) begin
        m_g     = first_from(ne, m_ptr);
        m_valid = 1'b1;
      end
    end else if (rdy) begin
      req = ne;
      if (la[m_g]) req[m_g] = 1'b0;
      cnt[m_g] = cnt[m_g] - 1;
      if (BURST && req[m_g] && (m_bcnt < int'(MB) - 1)) begin
        m_bcnt = m_bcnt + 1;
      end else begin
        m_ptr  = (m_g + 1) % 4;
        m_bcnt = 0;
        if (req == 4'b0000) m_valid = 1'b0;
        else                m_g     = first_from(req, m_ptr);
      end
    end
    oh = 4'b0000;
    if (m_valid) oh[m_g] = 1'b1;
    exp_q.push_back({m_valid, oh});
  endtask

  task automatic set_cnt(input int c0, input int c1, input int c2, input int c3);
    cnt[0] = c0; cnt[1] = c1; cnt[2] = c2; cnt[3] = c3;
  endtask

  // Monitor: one expectation per cycle, sampled just after the rising edge.
  initial begin
    logic [4:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({rd_valid, rd_sel} !== e) begin
          errors++;
          $display("FAIL grant @%0t: got valid=%b sel=%b, expected valid=%b sel=%b",
                   $time, rd_valid, rd_sel, e[4], e[3:0]);
        end
      end
    end
  end

  initial begin
    rst        = 1'b1;
    rd_ready   = 1'b0;
    q_nonempty = 4'b0000;
    q_last     = 4'b0000;
    m_valid    = 1'b0;
    m_g        = 0;
    m_ptr      = 0;
    m_bcnt     = 0;
    set_cnt(0, 0, 0, 0);

    // Reset held with all queues busy, then rotation at full ready.
    set_cnt(100, 100, 100, 100);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    repeat (14) step(1'b0, 1'b1);

    // Single queue held under backpressure, then its last entry popped.
    set_cnt(0, 0, 1, 0);
    step(1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0);

    // Only queues 0 and 3 requesting.
    set_cnt(50, 0, 0, 50);
    step(1'b1, 1'b1);
    repeat (8) step(1'b0, 1'b1);

    // Reset in the middle of a grant on queue 1; restart from pointer 0.
    set_cnt(0, 3, 0, 0);
    step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    cnt[0] = 3;
    step(1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b1);

    // Queue 0 drains after two pops while others stay busy.
    set_cnt(2, 100, 100, 100);
    step(1'b1, 1'b1);
    repeat (10) step(1'b0, 1'b1);

    // Random refills, backpressure and occasional resets.
    step(1'b1, 1'b0);
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 3) == 0) cnt[i] = cnt[i] + int'($urandom_range(1, 3));
      end
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0));
    end

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
